// File: rtl/reg_trigseq.sv
// reg_trigseq: two-event trigger sequencer on the OpenADC register bus.
// An edge on B must follow an edge on A within a programmable cycle window
// to produce a trigger pulse of programmable width on trig_out.
module reg_trigseq #(
  parameter int unsigned SEQ_CTRL_ADDR   = 57,
  parameter int unsigned SEQ_WINDOW_ADDR = 58,
  parameter int unsigned SEQ_STATUS_ADDR = 59
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic [5:0]  reg_address,
  input  logic [15:0] reg_bytecnt,
  input  logic [7:0]  reg_datai,
  output logic [7:0]  reg_datao,
  input  logic [15:0] reg_size,
  input  logic        reg_read,
  input  logic        reg_write,
  input  logic        reg_addrvalid,
  input  logic [5:0]  reg_hypaddress,
  output logic [15:0] reg_hyplen,
  output logic        reg_stream,
  input  logic        trig_a_i,
  input  logic        trig_b_i,
  output logic        trig_out
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_A = 2'd1,
    ST_WAIT_B = 2'd2,
    ST_FIRE   = 2'd3
  } state_t;

  // Register file
  logic [6:0]  ctrl_q;
  logic [31:0] window_q;
  logic [7:0]  tmo_cnt_q;
  logic [15:0] fire_cnt_q;

  // Input conditioning
  logic [2:0]  a_sync_q;
  logic [2:0]  b_sync_q;
  logic        edge_a_q;
  logic        edge_b_q;

  // Sequencer
  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  pcnt_q, pcnt_d;
  logic        trig_q;
  logic        fire_inc;
  logic        tmo_inc;
  logic        oneshot_clr;

  // Bus decode
  logic        sel_ctrl;
  logic        sel_win;
  logic        sel_stat;
  logic        bus_wr;
  logic        bus_rd;
  logic        byte0;
  logic        byte_in4;
  logic        ctrl_wr;
  logic        win_wr;
  logic        stat_wr;
  logic [31:0] status_word;
  logic        unused_size;

  wire ctrl_en      = ctrl_q[0];
  wire ctrl_inv_a   = ctrl_q[1];
  wire ctrl_inv_b   = ctrl_q[2];
  wire ctrl_oneshot = ctrl_q[3];
  wire [2:0] ctrl_pw = ctrl_q[6:4];

  assign unused_size = ^reg_size;
  assign reg_stream  = 1'b0;
  assign trig_out    = trig_q;

  // Address and byte-lane decode shared by reads and writes
  always_comb begin
    sel_ctrl = (reg_address == 6'(SEQ_CTRL_ADDR));
    sel_win  = (reg_address == 6'(SEQ_WINDOW_ADDR));
    sel_stat = (reg_address == 6'(SEQ_STATUS_ADDR));
    bus_wr   = reg_write & reg_addrvalid;
    bus_rd   = reg_read & reg_addrvalid;
    byte0    = (reg_bytecnt == 16'd0);
    byte_in4 = (reg_bytecnt < 16'd4);
    ctrl_wr  = bus_wr & sel_ctrl & byte0;
    win_wr   = bus_wr & sel_win & byte_in4;
    stat_wr  = bus_wr & sel_stat & byte_in4;
  end

  // CTRL register; a host write beats the oneshot enable clear
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      ctrl_q <= '0;
    end else if (ctrl_wr) begin
      ctrl_q <= reg_datai[6:0];
    end else if (oneshot_clr) begin
      ctrl_q[0] <= 1'b0;
    end
  end

  // WINDOW register, little-endian byte writes
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      window_q <= '0;
    end else if (win_wr) begin
      window_q[{reg_bytecnt[1:0], 3'b000} +: 8] <= reg_datai;
    end
  end

  // Polarity select, 2-FF synchronizer plus delay stage, registered rising-edge detect
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
      edge_a_q <= 1'b0;
      edge_b_q <= 1'b0;
    end else begin
      a_sync_q <= {a_sync_q[1:0], trig_a_i ^ ctrl_inv_a};
      b_sync_q <= {b_sync_q[1:0], trig_b_i ^ ctrl_inv_b};
      edge_a_q <= a_sync_q[1] & ~a_sync_q[2];
      edge_b_q <= b_sync_q[1] & ~b_sync_q[2];
    end
  end

  // Sequencer state, window countdown, pulse-width counter and output register
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      trig_q  <= (state_d == ST_FIRE);
    end
  end

  // Next-state logic. A live count of zero marks an unlimited wait, so a
  // window change mid-wait never alters the countdown already in progress.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pcnt_d      = pcnt_q;
    fire_inc    = 1'b0;
    tmo_inc     = 1'b0;
    oneshot_clr = 1'b0;
    if (!ctrl_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_WAIT_A;
        end
        ST_WAIT_A: begin
          if (edge_a_q) begin
            state_d = ST_WAIT_B;
            cnt_d   = window_q;
          end
        end
        ST_WAIT_B: begin
          if (edge_b_q) begin
            state_d  = ST_FIRE;
            pcnt_d   = ctrl_pw;
            fire_inc = 1'b1;
          end else if (edge_a_q) begin
            cnt_d = window_q;
          end else if (cnt_q != 32'd0) begin
            if (cnt_q == 32'd1) begin
              state_d = ST_WAIT_A;
              tmo_inc = 1'b1;
            end else begin
              cnt_d = cnt_q - 32'd1;
            end
          end
        end
        ST_FIRE: begin
          if (pcnt_q == 3'd0) begin
            if (ctrl_oneshot) begin
              state_d     = ST_IDLE;
              oneshot_clr = 1'b1;
            end else begin
              state_d = ST_WAIT_A;
            end
          end else begin
            pcnt_d = pcnt_q - 3'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Timeout (saturating) and fire (wrapping) counters; a STATUS write clears both
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      tmo_cnt_q  <= '0;
      fire_cnt_q <= '0;
    end else if (stat_wr) begin
      tmo_cnt_q  <= '0;
      fire_cnt_q <= '0;
    end else begin
      if (tmo_inc && (tmo_cnt_q != 8'hFF)) begin
        tmo_cnt_q <= tmo_cnt_q + 8'd1;
      end
      if (fire_inc) begin
        fire_cnt_q <= fire_cnt_q + 16'd1;
      end
    end
  end

  // Combinational read mux; zero whenever not selected
  always_comb begin
    status_word = {fire_cnt_q, tmo_cnt_q, 6'b000000, state_q};
    reg_datao   = '0;
    if (bus_rd) begin
      if (sel_ctrl && byte0) begin
        reg_datao = {1'b0, ctrl_q};
      end else if (sel_win && byte_in4) begin
        reg_datao = window_q[{reg_bytecnt[1:0], 3'b000} +: 8];
      end else if (sel_stat && byte_in4) begin
        reg_datao = status_word[{reg_bytecnt[1:0], 3'b000} +: 8];
      end
    end
  end

  // Register length query
  always_comb begin
    reg_hyplen = '0;
    if (reg_hypaddress == 6'(SEQ_CTRL_ADDR)) begin
      reg_hyplen = 16'd1;
    end else if (reg_hypaddress == 6'(SEQ_WINDOW_ADDR)) begin
      reg_hyplen = 16'd4;
    end else if (reg_hypaddress == 6'(SEQ_STATUS_ADDR)) begin
      reg_hyplen = 16'd4;
    end
  end

endmodule

// File: tb/tb_reg_trigseq.sv
// Bench for reg_trigseq: directed scenarios plus randomized A/B traffic
// checked against a deadline-based sequence model.
module tb_reg_trigseq;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        reset_i;
  logic [5:0]  reg_address;
  logic [15:0] reg_bytecnt;
  logic [7:0]  reg_datai;
  logic [7:0]  reg_datao;
  logic [15:0] reg_size;
  logic        reg_read;
  logic        reg_write;
  logic        reg_addrvalid;
  logic [5:0]  reg_hypaddress;
  logic [15:0] reg_hyplen;
  logic        reg_stream;
  logic        trig_a_i;
  logic        trig_b_i;
  logic        trig_out;

  int n_cmp = 0;
  int n_err = 0;

  reg_trigseq #(
    .SEQ_CTRL_ADDR(57),
    .SEQ_WINDOW_ADDR(58),
    .SEQ_STATUS_ADDR(59)
  ) dut (
    .clk(clk),
    .reset_i(reset_i),
    .reg_address(reg_address),
    .reg_bytecnt(reg_bytecnt),
    .reg_datai(reg_datai),
    .reg_datao(reg_datao),
    .reg_size(reg_size),
    .reg_read(reg_read),
    .reg_write(reg_write),
    .reg_addrvalid(reg_addrvalid),
    .reg_hypaddress(reg_hypaddress),
    .reg_hyplen(reg_hyplen),
    .reg_stream(reg_stream),
    .trig_a_i(trig_a_i),
    .trig_b_i(trig_b_i),
    .trig_out(trig_out)
  );

  initial begin
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reg_wr(input logic [5:0] a, input logic [15:0] bc, input logic [7:0] d);
    reg_address   = a;
    reg_bytecnt   = bc;
    reg_datai     = d;
    reg_write     = 1'b1;
    reg_addrvalid = 1'b1;
    @(posedge clk);
    #1;
    reg_write     = 1'b0;
    reg_addrvalid = 1'b0;
  endtask

  task automatic reg_rd(input logic [5:0] a, input logic [15:0] bc, output logic [7:0] d);
    reg_address   = a;
    reg_bytecnt   = bc;
    reg_read      = 1'b1;
    reg_addrvalid = 1'b1;
    #1;
    d             = reg_datao;
    reg_read      = 1'b0;
    reg_addrvalid = 1'b0;
  endtask

  // Runs n cycles and reports how many had trig_out high and the first such cycle
  task automatic watch(input int n, output int highs, output int first);
    highs = 0;
    first = 0;
    for (int i = 1; i <= n; i++) begin
      tick(1);
      if (trig_out === 1'b1) begin
        highs++;
        if (first == 0) first = i;
      end
    end
  endtask

  task automatic pulse_a();
    trig_a_i = 1'b1;
    tick(1);
    trig_a_i = 1'b0;
  endtask

  task automatic pulse_b();
    trig_b_i = 1'b1;
    tick(1);
    trig_b_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    int hyp_addr[4] = '{57, 58, 59, 60};
    int hyp_exp[4]  = '{1, 4, 4, 0};
    reset_i = 1'b0;
    #1 reset_i = 1'b1;
    #2;
    n_cmp++;
    if (trig_out !== 1'b0) begin n_err++; $display("FAIL reset_trig: got %b want 0", trig_out); end
    n_cmp++;
    if (reg_stream !== 1'b0) begin n_err++; $display("FAIL reset_stream: got %b want 0", reg_stream); end
    n_cmp++;
    if (reg_datao !== 8'h00) begin n_err++; $display("FAIL reset_datao_idle: got %h want 00", reg_datao); end
    for (int r = 57; r <= 59; r++) begin
      reg_rd(6'(r), 16'd0, d);
      n_cmp++;
      if (d !== 8'h00) begin n_err++; $display("FAIL reset_read_%0d: got %h want 00", r, d); end
    end
    for (int i = 0; i < 4; i++) begin
      reg_hypaddress = 6'(hyp_addr[i]);
      #1;
      n_cmp++;
      if (reg_hyplen !== 16'(hyp_exp[i])) begin
        n_err++;
        $display("FAIL hyplen_%0d: got %0d want %0d", hyp_addr[i], reg_hyplen, hyp_exp[i]);
      end
    end
    #1 reset_i = 1'b0;
    clk_en = 1'b1;
    tick(2);
  endtask

  task automatic test_basic();
    logic [7:0] d;
    int highs, first;
    reg_wr(6'd58, 16'd0, 8'd10);
    reg_wr(6'd58, 16'd1, 8'd0);
    reg_wr(6'd58, 16'd2, 8'd0);
    reg_wr(6'd58, 16'd3, 8'd0);
    reg_rd(6'd58, 16'd0, d);
    n_cmp++;
    if (d !== 8'd10) begin n_err++; $display("FAIL basic_window_rb: got %h want 0a", d); end
    reg_wr(6'd57, 16'd0, 8'h01);
    tick(4);
    trig_a_i = 1'b1;
    tick(2);
    trig_a_i = 1'b0;
    tick(3);
    trig_b_i = 1'b1;
    highs = 0;
    first = 0;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (i == 2) trig_b_i = 1'b0;
      if (trig_out === 1'b1) begin
        highs++;
        if (first == 0) first = i;
      end
    end
    n_cmp++;
    if (first != 4) begin n_err++; $display("FAIL basic_rise_edge: got %0d want 4", first); end
    n_cmp++;
    if (highs != 1) begin n_err++; $display("FAIL basic_width: got %0d want 1", highs); end
    reg_rd(6'd59, 16'd2, d);
    n_cmp++;
    if (d !== 8'h01) begin n_err++; $display("FAIL basic_fire_lo: got %h want 01", d); end
    reg_rd(6'd59, 16'd3, d);
    n_cmp++;
    if (d !== 8'h00) begin n_err++; $display("FAIL basic_fire_hi: got %h want 00", d); end
  endtask

  task automatic test_timeout();
    logic [7:0] d;
    int h1, h2, f;
    reg_wr(6'd58, 16'd0, 8'd4);
    tick(2);
    trig_a_i = 1'b1;
    tick(2);
    trig_a_i = 1'b0;
    watch(4, h1, f);
    trig_b_i = 1'b1;
    tick(2);
    trig_b_i = 1'b0;
    watch(10, h2, f);
    n_cmp++;
    if (h1 + h2 != 0) begin n_err++; $display("FAIL timeout_no_fire: got %0d high cycles want 0", h1 + h2); end
    reg_rd(6'd59, 16'd1, d);
    n_cmp++;
    if (d !== 8'd1) begin n_err++; $display("FAIL timeout_count: got %0d want 1", d); end
    reg_rd(6'd59, 16'd0, d);
    n_cmp++;
    if (d !== 8'd1) begin n_err++; $display("FAIL timeout_state: got %0d want 1", d); end
  endtask

  task automatic test_window_boundary();
    logic [7:0] d;
    int h, f;
    reg_wr(6'd58, 16'd0, 8'd8);
    tick(4);
    // B edge exactly W cycles after the A edge
    pulse_a();
    tick(7);
    pulse_b();
    watch(8, h, f);
    n_cmp++;
    if (h != 1) begin n_err++; $display("FAIL bound_w_fire: got %0d high cycles want 1", h); end
    reg_rd(6'd59, 16'd2, d);
    n_cmp++;
    if (d !== 8'd2) begin n_err++; $display("FAIL bound_w_firecnt: got %0d want 2", d); end
    tick(4);
    // one cycle too late
    pulse_a();
    tick(8);
    pulse_b();
    watch(8, h, f);
    n_cmp++;
    if (h != 0) begin n_err++; $display("FAIL bound_w1_nofire: got %0d high cycles want 0", h); end
    reg_rd(6'd59, 16'd1, d);
    n_cmp++;
    if (d !== 8'd2) begin n_err++; $display("FAIL bound_w1_tmo: got %0d want 2", d); end
    tick(4);
    // simultaneous edges: B ignored, waiting for a later B
    trig_a_i = 1'b1;
    trig_b_i = 1'b1;
    tick(1);
    trig_a_i = 1'b0;
    trig_b_i = 1'b0;
    tick(4);
    reg_rd(6'd59, 16'd0, d);
    n_cmp++;
    if (d !== 8'd2) begin n_err++; $display("FAIL bound_sim_state: got %0d want 2", d); end
    watch(12, h, f);
    n_cmp++;
    if (h != 0) begin n_err++; $display("FAIL bound_sim_nofire: got %0d high cycles want 0", h); end
    reg_rd(6'd59, 16'd1, d);
    n_cmp++;
    if (d !== 8'd3) begin n_err++; $display("FAIL bound_sim_tmo: got %0d want 3", d); end
  endtask

  task automatic test_oneshot();
    logic [7:0] d;
    int h, f;
    reg_wr(6'd57, 16'd0, 8'h39);
    tick(3);
    pulse_a();
    tick(2);
    pulse_b();
    watch(12, h, f);
    n_cmp++;
    if (h != 4) begin n_err++; $display("FAIL oneshot_width: got %0d high cycles want 4", h); end
    reg_rd(6'd57, 16'd0, d);
    n_cmp++;
    if (d !== 8'h38) begin n_err++; $display("FAIL oneshot_ctrl: got %h want 38", d); end
    tick(1);
    pulse_a();
    tick(2);
    pulse_b();
    watch(12, h, f);
    n_cmp++;
    if (h != 0) begin n_err++; $display("FAIL oneshot_second: got %0d high cycles want 0", h); end
    reg_rd(6'd59, 16'd0, d);
    n_cmp++;
    if (d !== 8'd0) begin n_err++; $display("FAIL oneshot_idle: got %0d want 0", d); end
    reg_rd(6'd59, 16'd2, d);
    n_cmp++;
    if (d !== 8'd3) begin n_err++; $display("FAIL oneshot_firecnt: got %0d want 3", d); end
    tick(1);
    reg_wr(6'd59, 16'd1, 8'hAA);
    for (int b = 1; b <= 3; b++) begin
      reg_rd(6'd59, 16'(b), d);
      n_cmp++;
      if (d !== 8'd0) begin n_err++; $display("FAIL status_clear_b%0d: got %h want 00", b, d); end
    end
    tick(1);
  endtask

  task automatic test_reset_in_fire();
    logic [7:0] d;
    bit seen = 1'b0;
    reg_wr(6'd57, 16'd0, 8'h71);
    tick(3);
    pulse_a();
    tick(2);
    pulse_b();
    for (int i = 0; i < 12 && !seen; i++) begin
      tick(1);
      if (trig_out === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL rstfire_rise: got no pulse want pulse within 12 cycles"); end
    tick(2);
    n_cmp++;
    if (trig_out !== 1'b1) begin n_err++; $display("FAIL rstfire_high3: got %b want 1", trig_out); end
    #2 reset_i = 1'b1;
    #1;
    n_cmp++;
    if (trig_out !== 1'b0) begin n_err++; $display("FAIL rstfire_async: got %b want 0", trig_out); end
    reg_rd(6'd57, 16'd0, d);
    n_cmp++;
    if (d !== 8'h00) begin n_err++; $display("FAIL rstfire_ctrl: got %h want 00", d); end
    #1 reset_i = 1'b0;
    tick(1);
  endtask

  // Random A/B traffic against a model built on absolute deadlines:
  // an A edge at cycle k opens acceptance through cycle k+W, a B edge
  // inside that span fires a pulse occupying cycles k..k+PW-1.
  task automatic test_random();
    localparam int NCYC = 300;
    logic [7:0] d;
    bit ha[NCYC + 5];
    bit hb[NCYC + 5];
    bit inv_a, inv_b, xa, xb, ea, eb;
    int w, pw, phase, deadline, fire_end, fires, tmos, exp_tmo;
    for (int sc = 0; sc < 4; sc++) begin
      inv_a = 1'($urandom_range(0, 1));
      inv_b = 1'($urandom_range(0, 1));
      w     = int'($urandom_range(0, 10));
      pw    = int'($urandom_range(1, 8));
      #2 reset_i = 1'b1;
      #1 reset_i = 1'b0;
      tick(1);
      trig_a_i = inv_a;
      trig_b_i = inv_b;
      reg_wr(6'd57, 16'd0, {1'b0, 3'(pw - 1), 1'b0, inv_b, inv_a, 1'b0});
      reg_wr(6'd58, 16'd0, 8'(w));
      tick(6);
      reg_wr(6'd57, 16'd0, {1'b0, 3'(pw - 1), 1'b0, inv_b, inv_a, 1'b1});
      tick(4);
      for (int i = 0; i < NCYC + 5; i++) begin
        ha[i] = 1'b0;
        hb[i] = 1'b0;
      end
      xa = 1'b0;
      xb = 1'b0;
      phase = 0;
      deadline = 0;
      fire_end = 0;
      fires = 0;
      tmos = 0;
      for (int k = 1; k <= NCYC; k++) begin
        if ($urandom_range(0, 3) == 0) xa = ~xa;
        if ($urandom_range(0, 3) == 0) xb = ~xb;
        trig_a_i = xa ^ inv_a;
        trig_b_i = xb ^ inv_b;
        tick(1);
        ha[k + 4] = xa;
        hb[k + 4] = xb;
        // level sampled at edge j is seen as an edge when acting at edge j+3
        ea = ha[k + 1] & ~ha[k];
        eb = hb[k + 1] & ~hb[k];
        if (phase == 0) begin
          if (ea) begin
            phase = 1;
            deadline = k + w;
          end
        end else if (phase == 1) begin
          if (eb) begin
            phase = 2;
            fire_end = k + pw;
            fires++;
          end else if (ea) begin
            deadline = k + w;
          end else if (w != 0 && k == deadline) begin
            phase = 0;
            tmos++;
          end
        end else begin
          if (k == fire_end) phase = 0;
        end
        n_cmp++;
        if (trig_out !== (phase == 2)) begin
          n_err++;
          $display("FAIL rand_trig sc%0d cyc%0d: got %b want %b", sc, k, trig_out, (phase == 2));
        end
      end
      exp_tmo = (tmos > 255) ? 255 : tmos;
      reg_rd(6'd59, 16'd1, d);
      n_cmp++;
      if (d !== 8'(exp_tmo)) begin n_err++; $display("FAIL rand_tmo sc%0d: got %0d want %0d", sc, d, exp_tmo); end
      reg_rd(6'd59, 16'd2, d);
      n_cmp++;
      if (d !== 8'(fires)) begin n_err++; $display("FAIL rand_fire sc%0d: got %0d want %0d", sc, d, fires); end
      tick(1);
    end
    trig_a_i = 1'b0;
    trig_b_i = 1'b0;
  endtask

  initial begin
    reset_i        = 1'b0;
    reg_address    = '0;
    reg_bytecnt    = '0;
    reg_datai      = '0;
    reg_size       = 16'd1;
    reg_read       = 1'b0;
    reg_write      = 1'b0;
    reg_addrvalid  = 1'b0;
    reg_hypaddress = '0;
    trig_a_i       = 1'b0;
    trig_b_i       = 1'b0;
    test_reset();
    test_basic();
    test_timeout();
    test_window_boundary();
    test_oneshot();
    test_reset_in_fire();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_trigseq.md
# reg_trigseq

Two-event trigger sequencer on the OpenADC register bus. It fires a programmable-width trigger pulse only when an edge on input B follows an edge on input A within a programmable cycle window. It sits beside the other reg_* peripherals: its read-data and hyplen outputs are ORed into the bus, and `trig_out` drives a spare trigger input of the capture/glitch trigger mux.

## Interface
Parameters:
- `SEQ_CTRL_ADDR`, 57, control register address (1 byte)
- `SEQ_WINDOW_ADDR`, 58, window register address (4 bytes, little-endian)
- `SEQ_STATUS_ADDR`, 59, status/counter register address (4 bytes)

Ports:
- `clk`  in  1  register-bus clock; the only clock
- `reset_i`  in  1  asynchronous active-high reset
- `reg_address`  in  6  current register address
- `reg_bytecnt`  in  16  byte index within register
- `reg_datai`  in  8  write data from host
- `reg_datao`  out  8  read data; 0 when not selected
- `reg_size`  in  16  transfer size; unused
- `reg_read`  in  1  read strobe
- `reg_write`  in  1  write strobe
- `reg_addrvalid`  in  1  address valid
- `reg_hypaddress`  in  6  length-query address
- `reg_hyplen`  out  16  register length for `reg_hypaddress`, else 0
- `reg_stream`  out  1  tied 0
- `trig_a_i`  in  1  asynchronous event A
- `trig_b_i`  in  1  asynchronous event B
- `trig_out`  out  1  sequenced trigger pulse

## Operation
- **CTRL register**
  - bit0 enable
  - bit1 invert A
  - bit2 invert B
  - bit3 oneshot
  - bits6:4 pulse width minus 1 (1–8 cycles)
  - bit7 reserved, reads 0
- **WINDOW register**
  - 32-bit W: B is accepted in the W cycles following the A-edge cycle.
  - W=0 means unlimited wait.
- **STATUS register**
  - byte0[1:0] state: IDLE=0, WAIT_A=1, WAIT_B=2, FIRE=3
  - byte1 timeout count, 8-bit, saturates at 255
  - bytes2–3 fire count, 16-bit, wraps
  - Any write to STATUS clears both counters.
- **Inputs**: each input is XORed with its invert bit, passed through a 2-FF synchronizer, then rising-edge detected (`sync2 & ~sync3`).
- **State machine**
  - Any state with enable=0 → IDLE.
  - IDLE → WAIT_A when enable=1.
  - WAIT_A: on edge_a → WAIT_B and load cnt=W. An edge_b in the same cycle as edge_a, or while in WAIT_A, is ignored.
  - WAIT_B, checked in priority order:
    - edge_b → FIRE, fire count +1.
    - Else edge_a → reload cnt=W (retrigger), stay in WAIT_B.
    - Else, if W≠0: when cnt==1 → WAIT_A with timeout count +1; otherwise cnt−1.
  - FIRE: `trig_out`=1 for PW=CTRL[6:4]+1 cycles. Then → WAIT_A, or, if oneshot, → IDLE and hardware clears CTRL bit0.
- **Register writes**: take effect on the `clk` edge where `reg_write & reg_addrvalid` and the address matches. Byte is selected by `reg_bytecnt`; bytes beyond the register length are ignored. A host write to CTRL in the same cycle as the oneshot clear wins.
- **Register reads**: `reg_datao` is combinational, equal to the selected byte when `reg_read & reg_addrvalid` and the address matches, else 0.
- **Length query**: `reg_hyplen` is combinational: 1/4/4 for CTRL/WINDOW/STATUS, else 0.
- **Reset values**: CTRL=0x00, WINDOW=0, counters 0, state IDLE, sync FFs 0, `trig_out`=0, `reg_datao`=0, `reg_stream`=0.

## Timing
- Input first sampled high at edge n → internal edge detect high in the cycle after edge n+2 → state change at edge n+3.
- `trig_out` is registered: it rises at edge n+3 after B is sampled and stays high exactly PW cycles.
- A window change in WAIT_B takes effect at the next A edge only; the live cnt is unaffected.
- Disabling during FIRE: `trig_out` drops at the next edge and the pulse is truncated; the fire count is kept.
- `reset_i` asserted mid-operation: all state and outputs go to reset values immediately, without waiting for `clk`.

## Test plan
- **Reset**: assert `reset_i` with no clock.
  - `trig_out`=0.
  - Reads of all three registers return 0.
  - `reg_hyplen` for 57/58/59/60 = 1/4/4/0.
- **Basic sequence**: CTRL=0x01, W=10; A pulse, then B 5 cycles later.
  - One 1-cycle `trig_out` pulse, rising 3 edges after B.
  - STATUS bytes2–3 = 0x0001.
- **Timeout**: W=4; B 6 cycles after A.
  - No `trig_out`.
  - Timeout count = 1.
  - STATUS byte0 = 1.
- **Window boundary**: W=8.
  - B edge detected exactly 8 cycles after the A-edge cycle → fires.
  - 9 cycles → timeout.
  - Simultaneous A/B edges → no fire, state WAIT_B.
- **Oneshot/width**: CTRL=0x39.
  - `trig_out` high 4 cycles.
  - CTRL reads 0x38 afterward.
  - A second A→B sequence produces no pulse.
  - A STATUS write clears the counters to 0.
- **Async reset in FIRE**: CTRL=0x71, assert `reset_i` during the third pulse cycle.
  - `trig_out` falls without a clock edge.
  - CTRL reads 0.
